// File: rtl/seq_param_2to1_rr_arb_mux.sv
// Two-input round-robin arbiter feeding a registered 2-to-1 mux; one output stage, 1-cycle latency.
// Optional per-input grant counters are enabled with the ARB_GRANT_CNT_EN macro.
module seq_param_2to1_rr_arb_mux #(
  parameter int nbits = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in0_val,
  output logic             in0_rdy,
  input  logic [nbits-1:0] in0_msg,
  input  logic             in1_val,
  output logic             in1_rdy,
  input  logic [nbits-1:0] in1_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [nbits-1:0] out_msg,
  output logic             out_src
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [15:0]      gnt0_cnt,
  output logic [15:0]      gnt1_cnt
`endif
);

  // Handshake: a beat moves on a rising edge when val && rdy; val never waits on rdy,
  // while in*_rdy may depend on in*_val and at most one input rdy is high at a time.
  logic prio;
  logic accept;
  logic grant;
  logic xfer0;
  logic xfer1;

  // The output stage can reload in the same cycle it drains.
  assign accept = !out_val || out_rdy;

  always_comb begin
    grant = 1'b0;
    if (in0_val && in1_val) begin
      grant = prio;
    end else if (in1_val) begin
      grant = 1'b1;
    end
  end

  assign in0_rdy = accept && in0_val && !grant;
  assign in1_rdy = accept && in1_val && grant;
  assign xfer0   = in0_val && in0_rdy;
  assign xfer1   = in1_val && in1_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_val <= 1'b0;
      out_msg <= '0;
      out_src <= 1'b0;
      prio    <= 1'b0;
    end else if (xfer0 || xfer1) begin
      out_val <= 1'b1;
      out_msg <= grant ? in1_msg : in0_msg;
      out_src <= grant;
      // Priority moves to the input that did not just win.
      prio    <= ~grant;
    end else if (out_val && out_rdy) begin
      out_val <= 1'b0;
    end
  end

`ifdef ARB_GRANT_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt0_cnt <= '0;
      gnt1_cnt <= '0;
    end else begin
      if (xfer0 && gnt0_cnt != 16'hFFFF) gnt0_cnt <= gnt0_cnt + 16'd1;
      if (xfer1 && gnt1_cnt != 16'hFFFF) gnt1_cnt <= gnt1_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_param_2to1_rr_arb_mux.sv
// Bench for seq_param_2to1_rr_arb_mux: directed vector table, corner sequences, randomized order check.
module tb_seq_param_2to1_rr_arb_mux;

  logic       clk;
  logic       reset_n;
  logic       in0_val;
  logic       in0_rdy;
  logic [7:0] in0_msg;
  logic       in1_val;
  logic       in1_rdy;
  logic [7:0] in1_msg;
  logic       out_val;
  logic       out_rdy;
  logic [7:0] out_msg;
  logic       out_src;
`ifdef ARB_GRANT_CNT_EN
  logic [15:0] gnt0_cnt;
  logic [15:0] gnt1_cnt;
`endif

  int n_tests;
  int n_fail;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  seq_param_2to1_rr_arb_mux #(.nbits(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in0_val(in0_val), .in0_rdy(in0_rdy), .in0_msg(in0_msg),
    .in1_val(in1_val), .in1_rdy(in1_rdy), .in1_msg(in1_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_src(out_src)
`ifdef ARB_GRANT_CNT_EN
    , .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       i0v;
    logic [7:0] i0m;
    logic       i1v;
    logic [7:0] i1m;
    logic       ordy;
    logic       e0r;
    logic       e1r;
    logic       eov;
    logic [7:0] eom;
    logic       eos;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [7:0] m0, input logic v1,
                       input logic [7:0] m1, input logic ordy);
    in0_val = v0; in0_msg = m0; in1_val = v1; in1_msg = m1; out_rdy = ordy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // one transfer cycle from a single input, out_rdy high
  task automatic single_xfer(input logic src);
    @(negedge clk);
    drive(!src, 8'h5A, src, 8'hA5, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    #1 reset_n = 1'b0;

    //           i0v  i0m    i1v  i1m    ordy  e0r  e1r  eov  eom    eos
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1};
    vecs[4]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
    vecs[5]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
    vecs[6]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
    vecs[7]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
    vecs[8]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1};
    vecs[9]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1};
    vecs[10] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1};
    vecs[11] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
    vecs[12] = '{1'b1, 8'h44, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0};
    vecs[13] = '{1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0};

    #2;
    check("reset_out_val", {31'd0, out_val}, 32'd0);
    check("reset_out_msg", {24'd0, out_msg}, 32'd0);
    check("reset_out_src", {31'd0, out_src}, 32'd0);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].i0v, vecs[i].i0m, vecs[i].i1v, vecs[i].i1m, vecs[i].ordy);
      #1;
      check($sformatf("v%0d_in0_rdy", i), {31'd0, in0_rdy}, {31'd0, vecs[i].e0r});
      check($sformatf("v%0d_in1_rdy", i), {31'd0, in1_rdy}, {31'd0, vecs[i].e1r});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_val", i), {31'd0, out_val}, {31'd0, vecs[i].eov});
      check($sformatf("v%0d_out_msg", i), {24'd0, out_msg}, {24'd0, vecs[i].eom});
      check($sformatf("v%0d_out_src", i), {31'd0, out_src}, {31'd0, vecs[i].eos});
    end

    // Asynchronous reset while a message is held and prio points at in1.
    @(negedge clk);
    drive(1'b1, 8'h66, 1'b0, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    check("pre_rst_out_val", {31'd0, out_val}, 32'd1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out_val", {31'd0, out_val}, 32'd0);
    check("async_rst_out_msg", {24'd0, out_msg}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 8'h77, 1'b1, 8'h88, 1'b1);
    #1;
    check("post_rst_in0_rdy", {31'd0, in0_rdy}, 32'd1);
    check("post_rst_in1_rdy", {31'd0, in1_rdy}, 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_out_msg", {24'd0, out_msg}, 32'h77);
    check("post_rst_out_src", {31'd0, out_src}, 32'd0);

`ifdef ARB_GRANT_CNT_EN
    do_reset();
    #1;
    check("cnt0_reset", {16'd0, gnt0_cnt}, 32'd0);
    check("cnt1_reset", {16'd0, gnt1_cnt}, 32'd0);
    repeat (3) single_xfer(1'b0);
    repeat (2) single_xfer(1'b1);
    check("cnt0_three", {16'd0, gnt0_cnt}, 32'd3);
    check("cnt1_two", {16'd0, gnt1_cnt}, 32'd2);
    repeat (65531) single_xfer(1'b0);
    check("cnt0_fffe", {16'd0, gnt0_cnt}, 32'hFFFE);
    repeat (3) single_xfer(1'b0);
    check("cnt0_saturate", {16'd0, gnt0_cnt}, 32'hFFFF);
    check("cnt1_unchanged", {16'd0, gnt1_cnt}, 32'd2);
`endif

    // Randomized traffic: per-input order, no drop/duplication, one-hot ready.
    do_reset();
    begin
      logic p0, p1;
      logic [6:0] c0, c1;
      logic [7:0] exp_m;
      p0 = 1'b0; p1 = 1'b0; c0 = '0; c1 = '0;
      for (int cyc = 0; cyc < 300; cyc++) begin
        @(negedge clk);
        if (!p0 && cyc < 280 && $urandom_range(0, 1) == 1) begin
          p0 = 1'b1; in0_msg = {1'b0, c0}; c0 = c0 + 7'd1;
        end
        if (!p1 && cyc < 280 && $urandom_range(0, 1) == 1) begin
          p1 = 1'b1; in1_msg = {1'b1, c1}; c1 = c1 + 7'd1;
        end
        in0_val = p0;
        in1_val = p1;
        out_rdy = (cyc >= 280) || ($urandom_range(0, 3) != 0);
        #1;
        if (in0_rdy && in1_rdy) check("rand_rdy_onehot", 32'd1, 32'd0);
        if (out_val && !out_rdy && (in0_rdy || in1_rdy)) check("rand_backpressure", 32'd1, 32'd0);
        if (out_val && out_rdy) begin
          if (out_src == 1'b0 && exp_q0.size() > 0) begin
            exp_m = exp_q0.pop_front();
            check("rand_in0_order", {24'd0, out_msg}, {24'd0, exp_m});
          end else if (out_src == 1'b1 && exp_q1.size() > 0) begin
            exp_m = exp_q1.pop_front();
            check("rand_in1_order", {24'd0, out_msg}, {24'd0, exp_m});
          end else begin
            check("rand_unexpected_out", {24'd0, out_msg}, 32'hFFFF_FFFF);
          end
        end
        if (in0_val && in0_rdy) begin exp_q0.push_back(in0_msg); p0 = 1'b0; end
        if (in1_val && in1_rdy) begin exp_q1.push_back(in1_msg); p1 = 1'b0; end
        @(posedge clk);
      end
      #1;
      check("rand_q0_drained", exp_q0.size(), 32'd0);
      check("rand_q1_drained", exp_q1.size(), 32'd0);
      check("rand_out_idle", {31'd0, out_val}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_param_2to1_rr_arb_mux.md
Name: seq_param_2to1_rr_arb_mux

Overview:
- Registered two-input round-robin arbiter feeding a parameterized 2-to-1 mux; merges two val/rdy request streams into one output stream.
- The internal grant drives the mux select.
- The winning message is captured in a single-entry output register: 1-cycle latency, full throughput.
- Sits directly upstream of the shared consumer; out_src exposes the select used for each message.

Parameters:
- nbits, 8, width of in0_msg, in1_msg, out_msg (must be >= 1).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in0_val  input  1  stream 0 message valid.
- in0_rdy  output  1  stream 0 ready; a transfer occurs when in0_val && in0_rdy.
- in0_msg  input  nbits  stream 0 payload.
- in1_val  input  1  stream 1 message valid.
- in1_rdy  output  1  stream 1 ready.
- in1_msg  input  nbits  stream 1 payload.
- out_val  output  1  output register holds a valid message.
- out_rdy  input  1  downstream ready; a transfer occurs when out_val && out_rdy.
- out_msg  output  nbits  registered payload.
- out_src  output  1  registered mux select of the held message (0 = in0, 1 = in1).

Behaviour:
- Reset (async assert, sync release): out_val=0, out_msg=0, out_src=0, prio=0 (in0 preferred). All outputs are registered except in*_rdy.
- accept = !out_val || out_rdy, so the output register can load in the same cycle it drains.
- Grant (combinational):
  - both valid -> grant=prio;
  - only in0_val -> grant=0;
  - only in1_val -> grant=1;
  - neither -> no grant.
- in0_rdy = accept && in0_val && grant==0. in1_rdy = accept && in1_val && grant==1.
- in*_rdy may depend on in*_val. At most one rdy is high per cycle.
- On transfer from input K at an edge: out_msg<=inK_msg, out_src<=K, out_val<=1, prio<=~K.
- prio changes only on a transfer.
- If out_val && out_rdy and there is no input transfer: out_val<=0. out_msg and out_src hold their stale values.
- If out_val && !out_rdy: out_val, out_msg and out_src hold; both in*_rdy=0 (backpressure).
- Latency: a message accepted at edge N is visible on out_* after edge N.
- Throughput: one message per cycle while out_rdy stays 1.
- Fairness: with both inputs continuously valid, grants alternate 0,1,0,1,...
- Single-requester bursts get full bandwidth. prio points to the idle input after each grant.
- Simultaneous drain and load in one cycle: the load wins and out_val stays 1.
- Reset mid-operation: a held message is discarded, prio returns to 0, no partial state remains.
- Messages are never dropped or duplicated. Per-input order is preserved.

Optional Feature:
- Macro: ARB_GRANT_CNT_EN.
- When defined, adds two ports:
  - gnt0_cnt output 16: count of in0 transfers since reset.
  - gnt1_cnt output 16: count of in1 transfers since reset.
- Counter rules: reset to 0, increment on each transfer from the matching input, saturate at 16'hFFFF (no wrap).
- When undefined, neither port nor counter logic exists. All other behaviour is identical.

Test Plan:
- Reset, then idle inputs with out_rdy=1 -> out_val=0, out_msg=0, out_src=0, in0_rdy=in1_rdy=0.
- nbits=8. in0_val=1, in0_msg=8'hA5 for one cycle, in1_val=0, out_rdy=1 -> next cycle out_val=1, out_msg=8'hA5, out_src=0; following cycle out_val=0.
- Both valid continuously (in0_msg=8'h11, in1_msg=8'h22), out_rdy=1 for 4 cycles -> out_msg sequence 11,22,11,22 and out_src 0,1,0,1.
- Message held with out_rdy=0 for 3 cycles while both inputs valid -> out_msg is stable and in0_rdy=in1_rdy=0 throughout; out_rdy=1 -> the next granted message loads the same edge.
- Assert reset_n=0 mid-cycle while out_val=1 and prio=1 -> out_val drops immediately (asynchronous). After release, both inputs valid -> in0 is granted first.
- With ARB_GRANT_CNT_EN:
  - 3 in0 and 2 in1 transfers -> gnt0_cnt=3, gnt1_cnt=2.
  - Force gnt0_cnt to 16'hFFFE, then 3 in0 transfers -> gnt0_cnt=16'hFFFF.
